// File: rtl/pc_sequencer.sv
// PC register and fetch sequencer: branch/jump/jr redirects, imem req/ready handshake, fetch strobe to decode.
// Optional macro DELAY_SLOT_EN: deliver (rather than flush) the fetch that overlaps a redirect.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imm_ext,
  input  logic [31:0] br_pc4,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic        req_q, req_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        addr_err_q, addr_err_d;

  logic        redirect;
  logic        handshake;
  logic        flush;
  logic [31:0] target;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;

  assign br_target = br_pc4 + (imm_ext << 2);
  assign j_target  = {br_pc4[31:28], jump_index, 2'b00};
  assign jr_target = {jr_addr[31:2], 2'b00};
  assign redirect  = jr | jump | branch_taken;
  assign target    = jr ? jr_target : (jump ? j_target : br_target);
  assign handshake = req_q & imem_ready;

  // A fetch overlapping a redirect (same edge or while a target is pending) is a wrong-path fetch.
`ifdef DELAY_SLOT_EN
  assign flush = 1'b0;
`else
  assign flush = redirect | pend_vld_q;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    pend_vld_d    = pend_vld_q;
    fetch_valid_d = 1'b0;
    fetch_pc_d    = fetch_pc_q;
    addr_err_d    = addr_err_q | (jr & (jr_addr[1:0] != 2'b00));
    case (state_q)
      IDLE, HOLD: begin
        if (redirect) pc_d = target;
        state_d = stall ? HOLD : REQ;
      end
      REQ: begin
        if (handshake) begin
          fetch_pc_d    = pc_q;
          fetch_valid_d = ~flush;
          pc_d          = pend_vld_q ? pend_pc_q : (redirect ? target : pc_q + 32'd4);
          pend_vld_d    = 1'b0;
          state_d       = stall ? HOLD : REQ;
        end else if (redirect && !pend_vld_q) begin
          // Request must stay stable at the old address; park the target until it completes.
          pend_vld_d = 1'b1;
          pend_pc_d  = target;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_pc_q     <= 32'h0;
      pend_vld_q    <= 1'b0;
      req_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= 32'h0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      pend_vld_q    <= pend_vld_d;
      req_q         <= req_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_PC = 0x0040_0000).
module tb_pc_sequencer;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imm_ext;
  logic [31:0] br_pc4;
  logic        branch_taken;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic        stall;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        addr_err;

  int passed = 0;
  int total  = 0;

  pc_sequencer #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .imm_ext(imm_ext), .br_pc4(br_pc4),
    .branch_taken(branch_taken), .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_addr(jr_addr), .stall(stall), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; stimulus and checks both happen here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; imm_ext = 32'h0; br_pc4 = 32'h0; branch_taken = 1'b0; jump = 1'b0;
    jump_index = 26'h0; jr = 1'b0; jr_addr = 32'h0; stall = 1'b0; imem_ready = 1'b1;
    step(); step();
    total++; if (pc !== 32'h0040_0000) $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0040_0000); else passed++;
    total++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", imem_req); else passed++;
    total++; if (fetch_valid !== 1'b0) $display("[TB] FAIL reset_fv: got %b expected 0", fetch_valid); else passed++;
    total++; if (fetch_pc !== 32'h0) $display("[TB] FAIL reset_fetch_pc: got %h expected 0", fetch_pc); else passed++;
    total++; if (addr_err !== 1'b0) $display("[TB] FAIL reset_addr_err: got %b expected 0", addr_err); else passed++;
    reset = 1'b0;
    step();
    total++; if (imem_req !== 1'b1) $display("[TB] FAIL first_req: got %b expected 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0040_0000) $display("[TB] FAIL first_addr: got %h expected %h", imem_addr, 32'h0040_0000); else passed++;
    total++; if (fetch_valid !== 1'b0) $display("[TB] FAIL first_fv_early: got %b expected 0", fetch_valid); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_fpc;
    exp_fpc = 32'h0040_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (fetch_valid !== 1'b1) $display("[TB] FAIL stream_fv%0d: got %b expected 1", i, fetch_valid); else passed++;
      total++; if (fetch_pc !== exp_fpc) $display("[TB] FAIL stream_fpc%0d: got %h expected %h", i, fetch_pc, exp_fpc); else passed++;
      exp_fpc = exp_fpc + 32'd4;
    end
    total++; if (imem_addr !== 32'h0040_000C) $display("[TB] FAIL stream_addr: got %h expected %h", imem_addr, 32'h0040_000C); else passed++;
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; br_pc4 = 32'h0040_0010; imm_ext = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    total++; if (imem_addr !== 32'h0040_0000) $display("[TB] FAIL branch_addr: got %h expected %h", imem_addr, 32'h0040_0000); else passed++;
    total++; if (fetch_valid !== DS) $display("[TB] FAIL branch_slot_fv: got %b expected %b", fetch_valid, DS); else passed++;
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0040_0000) $display("[TB] FAIL branch_fetch: got %b/%h expected 1/%h", fetch_valid, fetch_pc, 32'h0040_0000); else passed++;
  endtask

  task automatic test_jump_priority();
    jump = 1'b1; branch_taken = 1'b1; jump_index = 26'h0000100; br_pc4 = 32'h0040_0008; imm_ext = 32'h0000_0010;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    total++; if (imem_addr !== 32'h0000_0400) $display("[TB] FAIL jump_prio_addr: got %h expected %h", imem_addr, 32'h0000_0400); else passed++;
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_0400) $display("[TB] FAIL jump_fetch: got %b/%h expected 1/%h", fetch_valid, fetch_pc, 32'h0000_0400); else passed++;
  endtask

  task automatic test_jr_wait();
    imem_ready = 1'b0;
    step();
    total++; if (imem_addr !== 32'h0000_0404 || imem_req !== 1'b1) $display("[TB] FAIL wait0: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h404); else passed++;
    jr = 1'b1; jr_addr = 32'h0000_1000;
    step();
    jr = 1'b0;
    total++; if (imem_addr !== 32'h0000_0404 || imem_req !== 1'b1) $display("[TB] FAIL wait1: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h404); else passed++;
    step();
    total++; if (imem_addr !== 32'h0000_0404) $display("[TB] FAIL wait2: got %h expected %h", imem_addr, 32'h404); else passed++;
    total++; if (fetch_valid !== 1'b0) $display("[TB] FAIL wait_fv: got %b expected 0", fetch_valid); else passed++;
    imem_ready = 1'b1;
    step();
    total++; if (imem_addr !== 32'h0000_1000) $display("[TB] FAIL pend_addr: got %h expected %h", imem_addr, 32'h1000); else passed++;
    total++; if (fetch_valid !== DS) $display("[TB] FAIL pend_slot_fv: got %b expected %b", fetch_valid, DS); else passed++;
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_1000) $display("[TB] FAIL pend_fetch: got %b/%h expected 1/%h", fetch_valid, fetch_pc, 32'h1000); else passed++;
  endtask

  task automatic test_jr_misaligned();
    total++; if (addr_err !== 1'b0) $display("[TB] FAIL err_pre: got %b expected 0", addr_err); else passed++;
    jr = 1'b1; jr_addr = 32'h0000_1003;
    step();
    jr = 1'b0; jr_addr = 32'h0;
    total++; if (imem_addr !== 32'h0000_1000) $display("[TB] FAIL misalign_addr: got %h expected %h", imem_addr, 32'h1000); else passed++;
    total++; if (addr_err !== 1'b1) $display("[TB] FAIL err_set: got %b expected 1", addr_err); else passed++;
    step(); step();
    total++; if (addr_err !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", addr_err); else passed++;
    total++; if (imem_addr !== 32'h0000_1008) $display("[TB] FAIL misalign_seq: got %h expected %h", imem_addr, 32'h1008); else passed++;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_1008) $display("[TB] FAIL stall_complete: got %b/%h expected 1/%h", fetch_valid, fetch_pc, 32'h1008); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b0 || pc !== 32'h0000_100C) $display("[TB] FAIL stall_hold%0d: got %b/%h expected 0/%h", i, imem_req, pc, 32'h100C); else passed++;
      step();
    end
    total++; if (fetch_valid !== 1'b0) $display("[TB] FAIL stall_fv: got %b expected 0", fetch_valid); else passed++;
    stall = 1'b0;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_100C) $display("[TB] FAIL resume: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h100C); else passed++;
    stall = 1'b1;
    step();
    jr = 1'b1; jr_addr = 32'h0000_2000; stall = 1'b0;
    step();
    jr = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) $display("[TB] FAIL hold_redirect: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h2000); else passed++;
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0000_2000) $display("[TB] FAIL hold_redirect_fetch: got %b/%h expected 1/%h", fetch_valid, fetch_pc, 32'h2000); else passed++;
  endtask

  task automatic test_reset_mid_request();
    imem_ready = 1'b0;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_2004) $display("[TB] FAIL mid_wait: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h2004); else passed++;
    reset = 1'b1;
    step();
    imem_ready = 1'b1;
    total++; if (pc !== 32'h0040_0000 || imem_req !== 1'b0) $display("[TB] FAIL mid_reset: got %b/%h expected 0/%h", imem_req, pc, 32'h0040_0000); else passed++;
    total++; if (addr_err !== 1'b0) $display("[TB] FAIL err_cleared: got %b expected 0", addr_err); else passed++;
    reset = 1'b0;
    step();
    total++; if (fetch_valid !== 1'b0) $display("[TB] FAIL abandoned_fv: got %b expected 0", fetch_valid); else passed++;
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0040_0000) $display("[TB] FAIL post_reset_fetch: got %b/%h expected 1/%h", fetch_valid, fetch_pc, 32'h0040_0000); else passed++;
  endtask

  task automatic test_wrap();
    jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
    step();
    jr = 1'b0;
    step();
    total++; if (imem_addr !== 32'h0000_0000) $display("[TB] FAIL pc_wrap: got %h expected 0", imem_addr); else passed++;
    branch_taken = 1'b1; br_pc4 = 32'hFFFF_FFF0; imm_ext = 32'h0000_0008;
    step();
    branch_taken = 1'b0;
    total++; if (imem_addr !== 32'h0000_0010) $display("[TB] FAIL branch_wrap: got %h expected %h", imem_addr, 32'h10); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_branch();
    test_jump_priority();
    test_jr_wait();
    test_jr_misaligned();
    test_stall();
    test_reset_mid_request();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch sequencer for the MIPS core; sits directly downstream of the sign extender in the branch path. Consumes the 32-bit sign-extended immediate to form branch targets. Also resolves jump / jump-register redirects and drives a req/ready handshake to instruction memory. Emits each fetched PC with a valid strobe to decode.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- imm_ext  in  32  sign-extended 16-bit branch offset (word units)
- br_pc4  in  32  PC+4 of the instruction in decode (branch/jump base)
- branch_taken  in  1  single-cycle pulse: redirect to br_pc4 + (imm_ext << 2)
- jump  in  1  single-cycle pulse: redirect to {br_pc4[31:28], jump_index, 2'b00}
- jump_index  in  26  J-type target field
- jr  in  1  single-cycle pulse: redirect to jr_addr
- jr_addr  in  32  register-sourced target
- stall  in  1  hold PC, issue no new request
- imem_ready  in  1  memory accepts/completes current request
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- pc  out  32  current PC register
- fetch_valid  out  1  one-cycle strobe: fetch_pc is a live instruction
- fetch_pc  out  32  PC of the completed fetch
- addr_err  out  1  sticky: misaligned jr_addr seen

## Operation
- FSM states: IDLE, REQ, HOLD.
- IDLE: entered on reset; imem_req=0; next cycle -> REQ (or HOLD if stall).
- REQ: imem_req=1, imem_addr=pc. Handshake completes on edge with imem_req && imem_ready: fetch_pc <= pc, fetch_valid <= 1 (unless flushed), pc <= next_pc.
- next_pc priority: pending redirect > jr > jump > branch_taken > pc+4. Multiple redirect pulses in one cycle: highest priority only.
- Redirect while REQ and not imem_ready: target latched into pending register (pending_vld=1); request held unchanged at old address until ready. Completion loads pc from pending and clears pending_vld.
- Redirect with no request outstanding (IDLE/HOLD/REQ-idle edge): pc <= target directly.
- stall=1 in REQ with no handshake in progress, i.e. imem_ready=0 not yet asserted: request still held to completion; then -> HOLD. Stall never aborts an asserted request.
- HOLD: imem_req=0, pc held, redirects still accepted; stall=0 -> REQ next cycle.
- jr_addr[1:0] != 0: target low bits forced to 2'b00, addr_err <= 1 until reset.
- Arithmetic: 32-bit, modulo 2^32; pc+4 and branch sum wrap silently.

## Timing
- Reset (sync, highest priority): pc=RESET_PC, imem_req=0, fetch_valid=0, fetch_pc=0, addr_err=0, pending cleared, state IDLE. Reset mid-request abandons it; the memory response is ignored.
- First request: imem_req=1 in the second cycle after reset deassertion.
- Zero-wait memory (imem_ready tied 1, no stall): one fetch per cycle, pc advances by 4 each cycle.
- fetch_valid is high exactly one cycle, in the cycle after handshake completion.
- Redirect pulse at edge N with no outstanding request: imem_addr = target in cycle N+1.

## Configuration
- DELAY_SLOT_EN defined: fetch completing on the same edge as, or in flight during, a redirect is delivered with fetch_valid=1 (architectural delay slot).
- DELAY_SLOT_EN undefined: that fetch is flushed; fetch_valid stays 0 for it. Pending target is still applied.

## Test plan
- Reset, RESET_PC=32'h0040_0000, ready tied 1 -> fetch_pc sequence 0x400000, 0x400004, 0x400008; first fetch_valid 3 cycles after reset release.
- branch_taken with br_pc4=0x400010, imm_ext=32'hFFFF_FFFC -> next imem_addr 0x400000. Flushed/unflushed same-edge fetch per DELAY_SLOT_EN.
- jump and branch_taken same cycle, jump_index=26'h0000100, br_pc4=0x0040_0008 -> imem_addr 0x0000_0400; branch ignored.
- imem_ready low 3 cycles, jr to 0x1000 in cycle 1 -> imem_addr stays old until ready; then 0x1000. The old fetch is flushed without DELAY_SLOT_EN.
- jr_addr=0x1003 -> imem_addr 0x1000, addr_err=1 persisting until reset.
- stall asserted 4 cycles mid-stream -> imem_req=0, pc constant; resumes at same pc. Reset during wait -> pc=RESET_PC, fetch_valid never asserted for abandoned request.
